// File: rtl/gb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// gb_frame_sequencer
//
// APU frame sequencer. Divides the system clock down to the 512 Hz frame
// rate and steps an 8-step schedule that produces the one-cycle modulation
// strobes for the sound channels:
//   steps 0,2,4,6 : clk_length  (256 Hz)
//   steps 2,6     : clk_sweep   (128 Hz, coincident with clk_length)
//   step  7       : clk_vol_env (64 Hz)
// Everything is held idle (prescaler and step cleared) while apu_en is low.
//
// Build option:
//   FRAME_SEQ_EXT_DIV_EN - when defined, the internal prescaler is removed
//   and the frame tick is taken from the falling edge of the external
//   div_bit input (DIV register bit 4, or bit 5 in double speed). CLK_DIV
//   is then ignored.
//
// Parameters:
//   CLK_DIV          system clocks per frame step (>= 2)
//
// Ports:
//   clk              system clock, all state on posedge
//   rst_n            asynchronous active-low reset
//   apu_en           APU master enable (NR52 bit 7)
//   div_bit          DIV tap, only with FRAME_SEQ_EXT_DIV_EN
//   clk_length       one-cycle length-counter strobe
//   clk_sweep        one-cycle frequency-sweep strobe
//   clk_vol_env      one-cycle volume-envelope strobe
//   step             index of the next step to execute
//   len_next_clocks  1 when the next step clocks length (~step[0])
// ---------------------------------------------------------------------------
module gb_frame_sequencer #(
   parameter int unsigned CLK_DIV = 8192
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       apu_en,
`ifdef FRAME_SEQ_EXT_DIV_EN
   input  logic       div_bit,
`endif
   output logic       clk_length,
   output logic       clk_sweep,
   output logic       clk_vol_env,
   output logic [2:0] step,
   output logic       len_next_clocks
);

   logic frame_tick;

`ifdef FRAME_SEQ_EXT_DIV_EN

   // div_bit_q tracks div_bit unconditionally, so when apu_en rises the
   // previous sample is already current and no stale falling edge fires.
   logic div_bit_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_bit_q <= 1'b0;
      end else begin
         div_bit_q <= div_bit;
      end
   end

   assign frame_tick = apu_en & div_bit_q & ~div_bit;

`else

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("gb_frame_sequencer: CLK_DIV must be >= 2");
   end

   logic [CNT_W-1:0] presc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (!apu_en || presc == LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   assign frame_tick = apu_en && (presc == LAST);

`endif

   // Strobes are decoded from the step being executed (pre-increment value)
   // and registered on the same edge that advances step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step        <= '0;
         clk_length  <= 1'b0;
         clk_sweep   <= 1'b0;
         clk_vol_env <= 1'b0;
      end else if (!apu_en) begin
         step        <= '0;
         clk_length  <= 1'b0;
         clk_sweep   <= 1'b0;
         clk_vol_env <= 1'b0;
      end else if (frame_tick) begin
         step        <= step + 3'd1;
         clk_length  <= ~step[0];
         clk_sweep   <= step[1] & ~step[0];
         clk_vol_env <= &step;
      end else begin
         clk_length  <= 1'b0;
         clk_sweep   <= 1'b0;
         clk_vol_env <= 1'b0;
      end
   end

   assign len_next_clocks = ~step[0];

endmodule

// File: doc/gb_frame_sequencer.md
Name: gb_frame_sequencer

Overview:
- Generates the APU frame-sequencer timing strobes that schedule every per-channel modulation unit.
- Outputs: length-counter clock (256 Hz), frequency-sweep clock (128 Hz) and volume-envelope clock (64 Hz, drives clk_vol_env of each envelope unit on channels 1, 2, 4).
- Divides the system clock to 512 Hz, steps an 8-step schedule and gates everything on the APU master enable (NR52 bit 7).

Parameters:
- CLK_DIV, 8192, system clocks per frame step (4.194304 MHz / 512 Hz); legal range >= 2.
- CNT_W, $clog2(CLK_DIV), prescaler counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- apu_en  input  1  APU master enable (NR52 bit 7); 0 holds the sequencer idle.
- clk_length  output  1  one-cycle strobe; clocks channel length counters.
- clk_sweep  output  1  one-cycle strobe; clocks channel-1 frequency sweep.
- clk_vol_env  output  1  one-cycle strobe; clocks the envelope units.
- step  output  3  index of the next step to execute.
- len_next_clocks  output  1  1 when the next step clocks length, i.e. ~step[0]; used by channel length-enable quirk logic.
- div_bit  input  1  only present when FRAME_SEQ_EXT_DIV_EN is defined; DIV register bit 4 (bit 5 in double speed).

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0, step=0, all strobes 0.
- len_next_clocks=1 at reset.
- Reset mid-frame discards the partial count; strobes deassert immediately.
- apu_en=0 (synchronous):
  - Prescaler and step cleared to 0 on the next edge; all strobes 0 on that edge.
  - Held cleared while apu_en=0.
- apu_en=1:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - Terminal count (prescaler==CLK_DIV-1) is the frame tick.
- On the edge where the frame tick is taken:
  - Strobes decoded from the current step value (pre-increment) are registered.
  - step <= step+1 (mod 8, 7 wraps to 0).
- Strobes are high for exactly one clk cycle, the cycle after terminal count. Otherwise all strobes are 0.
- Schedule by step:
  - Steps 0, 2, 4, 6: clk_length.
  - Steps 2, 6: clk_sweep (coincident with clk_length).
  - Step 7: clk_vol_env.
  - Steps 1, 3, 5: no strobe.
- Latency: after apu_en rises (prescaler=0), the first strobe (clk_length, step 0) is high in the cycle after exactly CLK_DIV enabled clock edges. The edge that observes apu_en=1 counts as the first.
- apu_en falling in the same cycle as terminal count: disable wins; no strobe, step=0.
- Strobes never overlap between different steps. Minimum spacing between strobes is CLK_DIV cycles.
- Strobes and step are registered outputs; no combinational path from apu_en to the outputs.

Optional Feature:
- Macro: FRAME_SEQ_EXT_DIV_EN.
- Defined:
  - Internal prescaler is removed; CLK_DIV is ignored.
  - div_bit port is added and registered into div_bit_q.
  - Frame tick = div_bit_q & ~div_bit (falling edge), qualified by apu_en.
  - div_bit_q resets to 0 and tracks div_bit while apu_en=0, so enabling never produces a spurious edge.
  - Strobe/step rules are otherwise identical; the strobe is in the cycle after the edge is detected.
- Undefined: internal prescaler as above; no div_bit port.

Test Plan:
- Reset, CLK_DIV=4, apu_en=1 held for 32 cycles:
  - clk_length strobes at cycles 4, 12, 20, 28.
  - clk_sweep at 12, 28.
  - clk_vol_env at 32.
  - step sequence 1,2,...,7,0.
  - Each strobe exactly 1 cycle wide.
- Run to step=5, drop apu_en for 3 cycles, re-raise: step=0 and no strobes while low; next strobe is clk_length exactly 4 cycles after re-enable.
- Assert rst_n=0 asynchronously mid-count at step=3 between clock edges: outputs 0 and step=0 immediately. After release, first clk_length after 4 cycles.
- apu_en falls on the terminal-count cycle of step 7: no clk_vol_env pulse; step=0.
- Full frame: count per 8 steps is 4 clk_length, 2 clk_sweep, 1 clk_vol_env. len_next_clocks equals ~step[0] every cycle.
- FRAME_SEQ_EXT_DIV_EN defined, div_bit toggling every 3 cycles:
  - One step per div_bit falling edge.
  - Rising edges ignored.
  - Raising apu_en while div_bit=0 gives no immediate tick.
